wb_stage_pipe: RTL

Parametrised, registered write-back stage for the pipelined MIPS core. It replaces the purely combinational write-back path with a MEM/WB pipeline register. It selects between load data and ALU result, performs byte/half/word load extension, and drives the register-file write port and the forwarding bus. It honours the hazard unit's stall and flush, and optionally counts retired instructions.

---
 rtl/wb_stage_pipe_if.sv | 37 +++
 rtl/wb_stage_pipe.sv | 127 ++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe_if.sv
// MEM/WB bus for wb_stage_pipe: MEM-stage instruction fields in, register-file
// write port and forwarding bus out. The master drives MEM inputs, the slave is the stage.
interface wb_stage_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  mem_valid;
    logic                  wb_stall;
    logic                  wb_flush;
    logic [DATA_W-1:0]     mem_rdata;
    logic [DATA_W-1:0]     alu_res;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic [1:0]            ld_size;
    logic                  ld_unsigned;
    logic [2:0]            addr_lo;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_reg;
    logic [DATA_W-1:0]     fwd_data;

    modport master (
        output mem_valid, wb_stall, wb_flush, mem_rdata, alu_res, mem_to_reg,
               reg_write, dest_reg, ld_size, ld_unsigned, addr_lo,
        input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data
    );

    modport slave (
        input  mem_valid, wb_stall, wb_flush, mem_rdata, alu_res, mem_to_reg,
               reg_write, dest_reg, ld_size, ld_unsigned, addr_lo,
        output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// Registered MIPS write-back stage: load extension, result select, MEM/WB register
// with stall/flush, r0 write suppression. Optional retire counter under WB_RETIRE_CNT_EN.
module wb_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic           clk,
    input  logic           rst,
    wb_stage_pipe_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("wb_stage_pipe: DATA_W must be 32 or 64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("wb_stage_pipe: CNT_W must be at least 1");
    end

    logic [2:0]            byte_ofs;
    logic [2:0]            lane_ofs;
    logic [5:0]            shamt;
    logic [DATA_W-1:0]     shifted;
    logic [DATA_W-1:0]     keep_mask;
    logic                  sign_bit;
    logic [DATA_W-1:0]     ld_ext;
    logic [DATA_W-1:0]     next_wdata;

    logic                  valid_q;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  load_en;

    // Little-endian lane pick: shift the selected lane down to bit 0, then mask and extend.
    always_comb begin
        byte_ofs  = (DATA_W == 64) ? bus.addr_lo : {1'b0, bus.addr_lo[1:0]};
        lane_ofs  = 3'd0;
        keep_mask = '1;
        sign_bit  = 1'b0;
        shifted   = '0;
        shamt     = 6'd0;
        ld_ext    = '0;

        unique case (bus.ld_size)
            2'b00:   lane_ofs = byte_ofs;
            2'b01:   lane_ofs = {byte_ofs[2:1], 1'b0};
            2'b10:   lane_ofs = {byte_ofs[2], 2'b00};
            default: lane_ofs = 3'd0;
        endcase

        shamt   = {lane_ofs, 3'b000};
        shifted = bus.mem_rdata >> shamt;

        unique case (bus.ld_size)
            2'b00: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = shifted[7];
            end
            2'b01: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            2'b10: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase

        ld_ext = (shifted & keep_mask) |
                 ((!bus.ld_unsigned && sign_bit) ? ~keep_mask : '0);
    end

    assign next_wdata = bus.mem_to_reg ? ld_ext : bus.alu_res;
    assign load_en    = !bus.wb_flush && !bus.wb_stall;

    // Flush only kills the valid bit; the data fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (bus.wb_flush) begin
            valid_q <= 1'b0;
        end else if (!bus.wb_stall) begin
            valid_q <= bus.mem_valid;
            we_q    <= bus.reg_write;
            waddr_q <= bus.dest_reg;
            wdata_q <= next_wdata;
        end
    end

    assign bus.rf_we     = valid_q & we_q & (waddr_q != '0);
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.fwd_valid = bus.rf_we;
    assign bus.fwd_reg   = waddr_q;
    assign bus.fwd_data  = wdata_q;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts every valid instruction that enters the register, r0 targets included.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_en && bus.mem_valid) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign retire_cnt = cnt_q;
`else
    logic unused_load_en;
    assign unused_load_en = load_en;
`endif

endmodule
